// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM combinationally
// and registers the fetched word, its PC and PC+4 into the IF/ID register.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_accessable,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_d, fault_d;
  logic [31:0] inst_d, ipc_d, ipc4_d, fault_pc_d, count_d;

  assign rom_addr = pc_q;

  // NOTE: every next-state variable takes its held value first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = if_valid;
    inst_d     = if_inst;
    ipc_d      = if_pc;
    ipc4_d     = if_pc_plus4;
    fault_d    = fetch_fault;
    fault_pc_d = fault_pc;
    count_d    = fetch_count;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      state_d = RUN;
      fault_d = 1'b0;
    end else if (!id_stall && state_q == RUN) begin
      if (rom_accessable) begin
        inst_d  = rom_data;
        ipc_d   = pc_q;
        ipc4_d  = pc_q + 32'd4;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
        count_d = fetch_count + 32'd1;
      end else begin
        // pc holds so a redirect is the only way out of FAULT
        state_d    = FAULT;
        fault_d    = 1'b1;
        fault_pc_d = pc_q;
        valid_d    = 1'b0;
        inst_d     = NOP_INST;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      if_valid    <= 1'b0;
      if_inst     <= NOP_INST;
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h0;
      fetch_fault <= 1'b0;
      fault_pc    <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_valid    <= valid_d;
      if_inst     <= inst_d;
      if_pc       <= ipc_d;
      if_pc_plus4 <= ipc4_d;
      fetch_fault <= fault_d;
      fault_pc    <= fault_pc_d;
      fetch_count <= count_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a small boot/user ROM model and hand-computed expectations.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_addr, rom_data;
  logic        rom_accessable;
  logic        id_stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, fetch_fault;
  logic [31:0] if_inst, if_pc, if_pc_plus4, fault_pc, fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_accessable(rom_accessable), .id_stall(id_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .fetch_fault(fetch_fault),
    .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Boot segment: three words at 0x0..0x8. User segment: 16 words at 0x00400000.
  function automatic logic rom_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) &&
           ((a < 32'hC) || (a >= 32'h00400000 && a < 32'h00400040));
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h3c110040;
      32'h4:   return 32'h26310000;
      32'h8:   return 32'h02200008;
      default: return {16'h2402, a[15:0]};
    endcase
  endfunction

  assign rom_accessable = rom_ok(rom_addr);
  assign rom_data       = rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #2;
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_inst",  if_inst, 32'h0);
    check("rst_pc",    if_pc, 32'h0);
    check("rst_pc4",   if_pc_plus4, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'h0);
    check("rst_fpc",   fault_pc, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_addr",  rom_addr, 32'h0);
    step();
    reset = 1'b1;

    // Boot fetches
    step();
    check("boot0_valid", {31'b0, if_valid}, 32'h1);
    check("boot0_pc",    if_pc, 32'h0);
    check("boot0_inst",  if_inst, 32'h3c110040);
    check("boot0_pc4",   if_pc_plus4, 32'h4);
    step();
    check("boot1_pc",    if_pc, 32'h4);
    check("boot1_inst",  if_inst, 32'h26310000);
    step();
    check("boot2_pc",    if_pc, 32'h8);
    check("boot2_inst",  if_inst, 32'h02200008);
    check("boot2_count", fetch_count, 32'd3);
    check("boot2_addr",  rom_addr, 32'hC);

    // Redirect into the user segment
    redirect_valid = 1'b1; redirect_pc = 32'h00400000;
    step();
    redirect_valid = 1'b0;
    check("redir_valid", {31'b0, if_valid}, 32'h0);
    check("redir_inst",  if_inst, 32'h0);
    check("redir_addr",  rom_addr, 32'h00400000);
    check("redir_count", fetch_count, 32'd3);
    check("redir_pchold", if_pc, 32'h8);
    step();
    check("user0_valid", {31'b0, if_valid}, 32'h1);
    check("user0_pc",    if_pc, 32'h00400000);
    check("user0_inst",  if_inst, 32'h24020000);
    check("user0_count", fetch_count, 32'd4);
    step();
    check("user1_pc",    if_pc, 32'h00400004);

    // Stall four cycles
    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_pc",    if_pc, 32'h00400004);
      check("stall_inst",  if_inst, 32'h24020004);
      check("stall_addr",  rom_addr, 32'h00400008);
      check("stall_count", fetch_count, 32'd5);
    end
    id_stall = 1'b0;
    step();
    check("resume_pc",    if_pc, 32'h00400008);
    check("resume_inst",  if_inst, 32'h24020008);
    check("resume_count", fetch_count, 32'd6);

    // Unaligned redirect target faults one edge later
    redirect_valid = 1'b1; redirect_pc = 32'h00400002;
    step();
    redirect_valid = 1'b0;
    check("unal_nofault", {31'b0, fetch_fault}, 32'h0);
    step();
    check("unal_fault", {31'b0, fetch_fault}, 32'h1);
    check("unal_fpc",   fault_pc, 32'h00400002);
    check("unal_valid", {31'b0, if_valid}, 32'h0);
    check("unal_addr",  rom_addr, 32'h00400002);
    check("unal_pchold", if_pc, 32'h00400008);
    step();
    check("fault_hold",  {31'b0, fetch_fault}, 32'h1);
    check("fault_addr",  rom_addr, 32'h00400002);
    check("fault_count", fetch_count, 32'd6);

    // Redirect clears the fault, and overrides a concurrent stall
    redirect_valid = 1'b1; redirect_pc = 32'h0; id_stall = 1'b1;
    step();
    redirect_valid = 1'b0; id_stall = 1'b0;
    check("clr_fault", {31'b0, fetch_fault}, 32'h0);
    check("clr_fpc",   fault_pc, 32'h00400002);
    check("clr_addr",  rom_addr, 32'h0);
    repeat (3) step();
    check("reboot_pc",    if_pc, 32'h8);
    check("reboot_count", fetch_count, 32'd9);
    check("reboot_addr",  rom_addr, 32'hC);

    // Off the boot segment with a stall in the same cycle: fault delayed one edge
    id_stall = 1'b1;
    step();
    id_stall = 1'b0;
    check("offend_stall_fault", {31'b0, fetch_fault}, 32'h0);
    check("offend_stall_valid", {31'b0, if_valid}, 32'h1);
    step();
    check("offend_fault", {31'b0, fetch_fault}, 32'h1);
    check("offend_fpc",   fault_pc, 32'hC);
    check("offend_valid", {31'b0, if_valid}, 32'h0);
    check("offend_inst",  if_inst, 32'h0);

    // Recover, then async reset between edges while valid
    redirect_valid = 1'b1; redirect_pc = 32'h4;
    step();
    redirect_valid = 1'b0;
    step();
    check("pre_rst_valid", {31'b0, if_valid}, 32'h1);
    check("pre_rst_inst",  if_inst, 32'h26310000);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", {31'b0, if_valid}, 32'h0);
    check("arst_inst",  if_inst, 32'h0);
    check("arst_pc",    if_pc, 32'h0);
    check("arst_pc4",   if_pc_plus4, 32'h0);
    check("arst_fault", {31'b0, fetch_fault}, 32'h0);
    check("arst_fpc",   fault_pc, 32'h0);
    check("arst_count", fetch_count, 32'h0);
    check("arst_addr",  rom_addr, 32'h0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_pc",    if_pc, 32'h0);
    check("post_rst_count", fetch_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM address combinationally from it.
- Samples ROM data and the accessible flag, then registers the instruction, its PC and PC+4 into the IF/ID output for the decoder.
- Handles decode stalls, branch/jump redirects and fetch faults; faults cover unaligned or unmapped addresses.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset (boot ROM entry).
- NOP_INST, 32'h00000000, instruction word presented on if_inst whenever if_valid=0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rom_addr  output  32  fetch address to ROM; equals current pc register.
- rom_data  input  32  instruction word from ROM, combinational in rom_addr.
- rom_accessable  input  1  ROM reports rom_addr is aligned and mapped.
- id_stall  input  1  decode cannot accept; hold PC and IF/ID register.
- redirect_valid  input  1  branch/jump/exception taken this cycle.
- redirect_pc  input  32  target PC when redirect_valid=1.
- if_valid  output  1  IF/ID holds a real instruction.
- if_inst  output  32  fetched instruction (NOP_INST when invalid).
- if_pc  output  32  address of if_inst.
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
- fetch_fault  output  1  sticky; fetch stopped on an inaccessible address.
- fault_pc  output  32  address that faulted.
- fetch_count  output  32  number of instructions delivered (perf counter).

Behaviour:
- Reset (async, reset=0) sets the following; release takes effect at the next rising edge:
  - pc=RESET_PC, state=RUN, if_valid=0, if_inst=NOP_INST;
  - if_pc=0, if_pc_plus4=0, fetch_fault=0, fault_pc=0, fetch_count=0.
- rom_addr=pc at all times; no ROM read latency. Instruction at pc appears in IF/ID one cycle after pc is presented.
- States: RUN, FAULT.
- Per-edge priority, highest first:
  - 1. redirect_valid=1, any state:
    - pc<=redirect_pc; if_valid<=0; if_inst<=NOP_INST; state<=RUN;
    - fetch_fault<=0; fault_pc holds.
    - Redirect overrides id_stall.
  - 2. id_stall=1: pc, IF/ID, state, fault and counter all hold. A fault is not recorded while stalled; it is re-evaluated on the next unstalled edge because pc is unchanged.
  - 3. RUN, rom_accessable=1:
    - if_inst<=rom_data; if_pc<=pc; if_pc_plus4<=pc+4; if_valid<=1;
    - pc<=pc+4 (wraps 32'hFFFFFFFC->0); fetch_count<=fetch_count+1 (wraps).
  - 4. RUN, rom_accessable=0:
    - state<=FAULT; fetch_fault<=1; fault_pc<=pc; if_valid<=0; if_inst<=NOP_INST; pc holds.
  - 5. FAULT, no redirect: everything holds; if_valid stays 0; fetch_fault stays 1.
- Unaligned redirect target: the next RUN edge sees rom_accessable=0 and takes the fault path.
- if_pc and if_pc_plus4 hold their last values while if_valid=0.
- A pc+4 that leaves the mapped region (e.g. 32'h0000000C in the boot segment) faults on the following edge.
- All outputs are registered except rom_addr.

Test Plan:
- Reset, then 3 free-running edges with the boot ROM model:
  - if_pc = 0, 4, 8; if_inst = 3c110040, 26310000, 02200008; if_valid=1 from the first edge; fetch_count=3.
- Redirect to 32'h00400000 at the 3rd edge:
  - next cycle if_valid=0, pc=32'h00400000;
  - following cycle if_pc=32'h00400000, if_valid=1.
- id_stall=1 for 4 cycles mid-stream: if_inst, if_pc, rom_addr and fetch_count unchanged; on release, sequencing resumes at the held pc.
- redirect_pc=32'h00400002: one edge later fetch_fault=1, fault_pc=32'h00400002, if_valid=0, rom_addr stays 32'h00400002; redirect to 32'h00000000 clears the fault.
- Run off the boot segment to pc=32'h0000000C (inaccessible): FAULT entered; id_stall asserted in the same cycle delays the fault by exactly one cycle.
- Assert reset=0 asynchronously between edges while if_valid=1: all outputs reach reset values before the next edge; rom_addr=RESET_PC immediately.
